timer_irq_array: RTL and testbench

Multi-channel programmable timer interrupt generator for the MicroBlaze interrupt controller. It is the parametrised successor of the fixed single-period timer interrupt. Each of `NUM_CH` channels has:
- its own runtime period and pulse width,
- periodic or one-shot operation,
- pulse or level (acknowledged) output,
- a sticky overrun flag.

It sits in the 100 MHz fabric domain, driving the interrupt concat inputs directly.

---
 rtl/timer_irq_pkg.sv | 18 +
 rtl/timer_irq_channel.sv | 123 ++++++++++++
 rtl/timer_irq_array.sv | 45 ++++
 tb/tb_timer_irq_array.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/timer_irq_pkg.sv
// Shared types and constants for the timer interrupt array.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package timer_irq_pkg;

  // Per-channel run state.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } timer_st_t;

  // Smallest usable period: a period of 0 or 1 would expire every cycle with no low phase.
  localparam int unsigned MIN_PERIOD = 2;
  // A zero width would produce no pulse at all, so it is treated as one cycle.
  localparam int unsigned MIN_WIDTH  = 1;

endpackage

// File: rtl/timer_irq_channel.sv
// One programmable timer channel: period counter, one-shot/periodic FSM, pulse/level irq and sticky overrun.
// Latency: irq_out rises P edges after the enable edge; falls one edge after pulse end or ack.
// Backpressure: none; level mode holds irq_out until irq_ack, a new expire meanwhile flags overrun.
module timer_irq_channel #(
  parameter int CNT_W = 24,
  parameter int PW_W  = 12
) (
  input  logic             clk_100,
  input  logic             rst_100,
  input  logic             enable,
  input  logic             oneshot,
  input  logic             level,
  input  logic [CNT_W-1:0] period,
  input  logic [PW_W-1:0]  width,
  input  logic             irq_ack,
  input  logic             overrun_clr,
  output logic             irq_out,
  output logic             irq_overrun
);
  import timer_irq_pkg::*;

  timer_st_t        st_q, st_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [PW_W-1:0]  hold_q, hold_d;
  logic             irq_q, irq_d;
  logic             ovr_q, ovr_set;
  logic             oneshot_q, oneshot_d;

  logic [CNT_W-1:0] eff_period;
  logic [PW_W-1:0]  eff_width;
  logic             expire;
  logic             ack_hit;
  logic             pulse_end;

  // Clamp the live period/width and decode this cycle's events.
  always_comb begin
    eff_period = (period < CNT_W'(MIN_PERIOD)) ? CNT_W'(MIN_PERIOD) : period;
    eff_width  = (width  < PW_W'(MIN_WIDTH))   ? PW_W'(MIN_WIDTH)   : width;
    // >= so a period lowered below the running count expires on the next cycle
    expire     = (st_q == RUN) && (cnt_q >= (eff_period - CNT_W'(1)));
    ack_hit    = level && irq_ack && irq_q;
    // >= so a width lowered during an active pulse ends it promptly
    pulse_end  = !level && irq_q && (hold_q >= (eff_width - PW_W'(1)));
  end

  // Next state, counters, interrupt output and overrun request.
  always_comb begin
    st_d      = st_q;
    cnt_d     = cnt_q;
    hold_d    = hold_q;
    irq_d     = irq_q;
    oneshot_d = oneshot_q;
    ovr_set   = 1'b0;

    if (!enable) begin
      st_d   = IDLE;
      cnt_d  = '0;
      hold_d = '0;
      irq_d  = 1'b0;
    end else begin
      case (st_q)
        IDLE: begin
          st_d      = RUN;
          cnt_d     = '0;
          oneshot_d = oneshot;
        end
        RUN: begin
          if (expire) begin
            cnt_d = '0;
            if (oneshot_q) st_d = DONE;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        DONE: begin
          cnt_d = '0;
        end
        default: begin
          st_d  = IDLE;
          cnt_d = '0;
        end
      endcase

      // An expire always wins over ack or pulse end; retriggering an active irq is an overrun
      // unless the same cycle acknowledges it.
      if (st_q != IDLE) begin
        if (expire) begin
          irq_d   = 1'b1;
          hold_d  = '0;
          ovr_set = irq_q && !(level && irq_ack);
        end else if (ack_hit || pulse_end) begin
          irq_d  = 1'b0;
          hold_d = '0;
        end else if (irq_q && !level) begin
          hold_d = hold_q + PW_W'(1);
        end
      end
    end
  end

  // State register; overrun set takes priority over the global clear.
  always_ff @(posedge clk_100) begin
    if (rst_100) begin
      st_q      <= IDLE;
      cnt_q     <= '0;
      hold_q    <= '0;
      irq_q     <= 1'b0;
      ovr_q     <= 1'b0;
      oneshot_q <= 1'b0;
    end else begin
      st_q      <= st_d;
      cnt_q     <= cnt_d;
      hold_q    <= hold_d;
      irq_q     <= irq_d;
      oneshot_q <= oneshot_d;
      ovr_q     <= ovr_set | (ovr_q & ~overrun_clr);
    end
  end

  assign irq_out     = irq_q;
  assign irq_overrun = ovr_q;

endmodule

// File: rtl/timer_irq_array.sv
// Array of NUM_CH independent timer interrupt channels feeding the interrupt controller.
// Latency: registered irq_out per channel; irq_any is a same-cycle OR of those registers.
// Backpressure: none; each channel in level mode waits for its own irq_ack.
module timer_irq_array #(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 24,
  parameter int PW_W   = 12
) (
  input  logic                    clk_100,
  input  logic                    rst_100,
  input  logic [NUM_CH-1:0]       ch_enable,
  input  logic [NUM_CH-1:0]       ch_oneshot,
  input  logic [NUM_CH-1:0]       ch_level,
  input  logic [NUM_CH*CNT_W-1:0] period,
  input  logic [NUM_CH*PW_W-1:0]  width,
  input  logic [NUM_CH-1:0]       irq_ack,
  input  logic                    overrun_clr,
  output logic [NUM_CH-1:0]       irq_out,
  output logic [NUM_CH-1:0]       irq_overrun,
  output logic                    irq_any
);

  // One channel per generate iteration; overrun_clr fans out to all of them.
  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    timer_irq_channel #(
      .CNT_W (CNT_W),
      .PW_W  (PW_W)
    ) u_ch (
      .clk_100     (clk_100),
      .rst_100     (rst_100),
      .enable      (ch_enable[g]),
      .oneshot     (ch_oneshot[g]),
      .level       (ch_level[g]),
      .period      (period[g*CNT_W +: CNT_W]),
      .width       (width[g*PW_W +: PW_W]),
      .irq_ack     (irq_ack[g]),
      .overrun_clr (overrun_clr),
      .irq_out     (irq_out[g]),
      .irq_overrun (irq_overrun[g])
    );
  end

  assign irq_any = |irq_out;

endmodule

// File: tb/tb_timer_irq_array.sv
// Bench for timer_irq_array: directed vector table, hand sequences, random run against a reference model.
// Latency: checks sampled 1 time unit after each rising clk_100 edge.
// Backpressure: n/a.
module tb_timer_irq_array;
  localparam int NUM_CH = 4;
  localparam int CNT_W  = 24;
  localparam int PW_W   = 12;

  logic                    clk_100;
  logic                    rst_100;
  logic [NUM_CH-1:0]       ch_enable;
  logic [NUM_CH-1:0]       ch_oneshot;
  logic [NUM_CH-1:0]       ch_level;
  logic [NUM_CH*CNT_W-1:0] period;
  logic [NUM_CH*PW_W-1:0]  width;
  logic [NUM_CH-1:0]       irq_ack;
  logic                    overrun_clr;
  logic [NUM_CH-1:0]       irq_out;
  logic [NUM_CH-1:0]       irq_overrun;
  logic                    irq_any;

  timer_irq_array #(
    .NUM_CH (NUM_CH),
    .CNT_W  (CNT_W),
    .PW_W   (PW_W)
  ) dut (
    .clk_100     (clk_100),
    .rst_100     (rst_100),
    .ch_enable   (ch_enable),
    .ch_oneshot  (ch_oneshot),
    .ch_level    (ch_level),
    .period      (period),
    .width       (width),
    .irq_ack     (irq_ack),
    .overrun_clr (overrun_clr),
    .irq_out     (irq_out),
    .irq_overrun (irq_overrun),
    .irq_any     (irq_any)
  );

  initial clk_100 = 1'b0;
  always #5 clk_100 = ~clk_100;

  int checks   = 0;
  int failures = 0;

  // Bench-side copies of the configured period/width, used by the model.
  int p_cfg[NUM_CH];
  int w_cfg[NUM_CH];

  // Reference model: time since last expire, high time of the current pulse, run flags.
  bit m_act[NUM_CH];
  bit m_done[NUM_CH];
  bit m_os[NUM_CH];
  bit m_out[NUM_CH];
  bit m_ovr[NUM_CH];
  int m_phase[NUM_CH];
  int m_age[NUM_CH];

  // Directed expectation table for the combined test-plan scenario.
  typedef struct {
    int         cyc;
    logic [3:0] irq;
    logic [3:0] ovr;
  } vec_t;
  localparam int NT = 21;
  vec_t tbl[NT];

  task automatic chk(input string nm, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_100);
    #1;
  endtask

  task automatic cfg(input int i, input bit en, input bit os, input bit lv, input int p, input int w);
    ch_enable[i]  = en;
    ch_oneshot[i] = os;
    ch_level[i]   = lv;
    p_cfg[i]      = p;
    w_cfg[i]      = w;
    period[i*CNT_W +: CNT_W] = CNT_W'(p);
    width[i*PW_W +: PW_W]    = PW_W'(w);
  endtask

  task automatic do_reset();
    rst_100     = 1'b1;
    irq_ack     = '0;
    overrun_clr = 1'b0;
    for (int i = 0; i < NUM_CH; i++) cfg(i, 1'b0, 1'b0, 1'b0, 10, 1);
    repeat (3) tick();
  endtask

  // Advance the model by one clock edge using the inputs present during the cycle just ended.
  task automatic model_step();
    for (int i = 0; i < NUM_CH; i++) begin
      int ep;
      int ew;
      bit fire;
      bit set;
      set = 1'b0;
      if (rst_100) begin
        m_act[i] = 0; m_done[i] = 0; m_os[i] = 0; m_out[i] = 0;
        m_ovr[i] = 0; m_phase[i] = 0; m_age[i] = 0;
      end else begin
        if (!ch_enable[i]) begin
          m_act[i] = 0; m_phase[i] = 0; m_age[i] = 0; m_out[i] = 0;
        end else if (!m_act[i]) begin
          m_act[i] = 1; m_done[i] = 0; m_os[i] = ch_oneshot[i]; m_phase[i] = 0;
        end else begin
          ep   = (p_cfg[i] < 2) ? 2 : p_cfg[i];
          ew   = (w_cfg[i] < 1) ? 1 : w_cfg[i];
          fire = !m_done[i] && (m_phase[i] >= ep - 1);
          if (fire) begin
            m_phase[i] = 0;
            if (m_os[i]) m_done[i] = 1;
          end else if (!m_done[i]) begin
            m_phase[i]++;
          end
          if (fire) begin
            set      = m_out[i] && !(ch_level[i] && irq_ack[i]);
            m_out[i] = 1;
            m_age[i] = 0;
          end else if (m_out[i] && (ch_level[i] ? irq_ack[i] : (m_age[i] >= ew - 1))) begin
            m_out[i] = 0;
          end else if (m_out[i] && !ch_level[i]) begin
            m_age[i]++;
          end
        end
        m_ovr[i] = set | (m_ovr[i] & !overrun_clr);
      end
    end
  endtask

  initial begin
    logic [3:0] e_irq;
    logic [3:0] e_ovr;

    tbl[0]  = '{0,  4'b0000, 4'b0000};
    tbl[1]  = '{8,  4'b1010, 4'b0000};
    tbl[2]  = '{9,  4'b0000, 4'b0000};
    tbl[3]  = '{10, 4'b1001, 4'b0000};
    tbl[4]  = '{12, 4'b1001, 4'b0000};
    tbl[5]  = '{13, 4'b0000, 4'b0000};
    tbl[6]  = '{16, 4'b1100, 4'b0000};
    tbl[7]  = '{20, 4'b1101, 4'b0000};
    tbl[8]  = '{21, 4'b0001, 4'b0000};
    tbl[9]  = '{24, 4'b1000, 4'b0000};
    tbl[10] = '{30, 4'b1011, 4'b0000};
    tbl[11] = '{31, 4'b0001, 4'b0000};
    tbl[12] = '{32, 4'b1101, 4'b0000};
    tbl[13] = '{38, 4'b1100, 4'b0000};
    tbl[14] = '{47, 4'b0100, 4'b0000};
    tbl[15] = '{48, 4'b1100, 4'b0100};
    tbl[16] = '{51, 4'b0101, 4'b0000};
    tbl[17] = '{57, 4'b0100, 4'b0000};
    tbl[18] = '{59, 4'b1100, 4'b0000};
    tbl[19] = '{64, 4'b1100, 4'b1100};
    tbl[20] = '{70, 4'b1101, 4'b1100};

    for (int i = 0; i < NUM_CH; i++) begin
      m_act[i] = 0; m_done[i] = 0; m_os[i] = 0; m_out[i] = 0;
      m_ovr[i] = 0; m_phase[i] = 0; m_age[i] = 0;
    end

    // Reset state
    do_reset();
    chk("reset_irq_out", int'(irq_out), 0);
    chk("reset_overrun", int'(irq_overrun), 0);
    chk("reset_irq_any", int'(irq_any), 0);

    // Test plan channels 0..3 running together; enable is sampled at edge 0.
    cfg(0, 1'b1, 1'b0, 1'b0, 10, 3);
    cfg(1, 1'b1, 1'b1, 1'b0, 8, 1);
    cfg(2, 1'b1, 1'b0, 1'b1, 16, 0);
    cfg(3, 1'b1, 1'b0, 1'b0, 0, 0);
    rst_100 = 1'b0;
    for (int k = 0; k <= 70; k++) begin
      tick();
      for (int t = 0; t < NT; t++) begin
        if (tbl[t].cyc == k) begin
          chk($sformatf("plan_irq@%0d", k), int'(irq_out), int'(tbl[t].irq));
          chk($sformatf("plan_ovr@%0d", k), int'(irq_overrun), int'(tbl[t].ovr));
          chk($sformatf("plan_any@%0d", k), int'(irq_any), int'(|tbl[t].irq));
        end
      end
      irq_ack     = '0;
      overrun_clr = 1'b0;
      if (k == 20) begin
        irq_ack[2]   = 1'b1;
        ch_enable[1] = 1'b0;
      end
      if (k == 21) ch_enable[1] = 1'b1;
      if (k == 50) overrun_clr = 1'b1;
      if (k == 55) cfg(3, 1'b1, 1'b0, 1'b0, 5, 7);
    end

    // Reset in the middle of operation, then restart from the reset release.
    do_reset();
    cfg(0, 1'b1, 1'b0, 1'b0, 7, 1);
    cfg(1, 1'b1, 1'b0, 1'b0, 11, 1);
    cfg(2, 1'b1, 1'b0, 1'b0, 13, 1);
    cfg(3, 1'b1, 1'b0, 1'b0, 17, 1);
    rst_100 = 1'b0;
    for (int k = 0; k <= 60; k++) begin
      tick();
      if (k == 49) begin
        chk("rst_pre_irq@49", int'(irq_out), 1);
        rst_100 = 1'b1;
      end
      if (k == 50) begin
        chk("rst_irq@50", int'(irq_out), 0);
        chk("rst_ovr@50", int'(irq_overrun), 0);
        chk("rst_any@50", int'(irq_any), 0);
        rst_100 = 1'b0;
      end
      if (k == 57) chk("rst_restart_irq@57", int'(irq_out), 0);
      if (k == 58) chk("rst_restart_irq@58", int'(irq_out), 1);
    end

    // Live period decrease below the count, then ack coincident with expire in level mode.
    do_reset();
    cfg(0, 1'b1, 1'b0, 1'b1, 100, 0);
    rst_100 = 1'b0;
    for (int k = 0; k <= 52; k++) begin
      tick();
      irq_ack = '0;
      if (k == 40) begin
        chk("shrink_irq@40", int'(irq_out), 0);
        cfg(0, 1'b1, 1'b0, 1'b1, 5, 0);
      end
      if (k == 41) chk("shrink_irq@41", int'(irq_out), 1);
      if (k == 45) irq_ack[0] = 1'b1;
      if (k == 46) begin
        chk("ack_expire_irq@46", int'(irq_out), 1);
        chk("ack_expire_ovr@46", int'(irq_overrun), 0);
      end
      if (k == 47) chk("ack_expire_irq@47", int'(irq_out), 1);
      if (k == 51) chk("noack_ovr@51", int'(irq_overrun), 1);
    end

    // Randomised run against the reference model.
    rst_100 = 1'b1;
    for (int n = 0; n < 2000; n++) begin
      for (int i = 0; i < NUM_CH; i++) begin
        if ($urandom_range(0, 39) == 0) begin
          ch_enable[i] = ~ch_enable[i];
          if (!ch_enable[i]) begin
            ch_oneshot[i] = ($urandom_range(0, 3) == 0);
            ch_level[i]   = ($urandom_range(0, 1) == 0);
          end
        end
        if ($urandom_range(0, 29) == 0)
          cfg(i, ch_enable[i], ch_oneshot[i], ch_level[i], int'($urandom_range(0, 20)), w_cfg[i]);
        if ($urandom_range(0, 29) == 0)
          cfg(i, ch_enable[i], ch_oneshot[i], ch_level[i], p_cfg[i], int'($urandom_range(0, 8)));
        irq_ack[i] = ($urandom_range(0, 3) == 0);
      end
      overrun_clr = ($urandom_range(0, 19) == 0);
      rst_100     = (n < 2) || ($urandom_range(0, 299) == 0);
      @(posedge clk_100);
      model_step();
      #1;
      for (int i = 0; i < NUM_CH; i++) begin
        e_irq[i] = m_out[i];
        e_ovr[i] = m_ovr[i];
      end
      chk($sformatf("rnd_irq@%0d", n), int'(irq_out), int'(e_irq));
      chk($sformatf("rnd_ovr@%0d", n), int'(irq_overrun), int'(e_ovr));
      chk($sformatf("rnd_any@%0d", n), int'(irq_any), int'(|e_irq));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
